// File: rtl/vmode_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vmode_pkg
// Description : Shared encodings for the video mode sequencer, the UART
//               command decoder and the MMCM DRP block.
// Revision    : 1.0  initial release
// ============================================================================
package vmode_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_BOOT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_WAIT_FRAME = 3'd2,
    ST_BLANK      = 3'd3,
    ST_RECONFIG   = 3'd4,
    ST_APPLY      = 3'd5,
    ST_SETTLE     = 3'd6,
    ST_ERR        = 3'd7
  } vmode_state_e;

  // Image source codes
  typedef enum logic [1:0] {
    IMG_TP_DEFAULT = 2'b00,
    IMG_TP1        = 2'b01,
    IMG_TP2        = 2'b10,
    IMG_LIVE       = 2'b11
  } img_src_e;

  // Resolution codes
  typedef enum logic [1:0] {
    RES_640  = 2'b00,
    RES_800  = 2'b01,
    RES_1280 = 2'b10,
    RES_1920 = 2'b11
  } res_e;

  // One complete output selection (image, resolution, port)
  typedef struct packed {
    logic [1:0] img;
    logic [1:0] res;
    logic       out;
  } vmode_sel_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Clearable, enabled up-counter that saturates at all-ones and
//               flags when its value equals a supplied terminal count.
// Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 21
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count up while enabled; clear wins; hold at all-ones instead of wrapping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign hit_o = (cnt_q == term_i);

endmodule
`default_nettype wire

// File: rtl/video_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : video_mode_sequencer
// Description : Applies image/resolution/output requests at frame boundaries,
//               blanking the output and driving pixel-clock reconfiguration
//               with lock supervision when the resolution changes.
// Revision    : 1.0  initial release
// ============================================================================
module video_mode_sequencer #(
  parameter int BLANK_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 1048576,
  parameter int CNT_W         = 21
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] req_img,
  input  logic [1:0] req_res,
  input  logic       req_out,
  input  logic       req_soft_rst,
  input  logic       frame_end,
  input  logic       clk_locked,
  output logic [1:0] img_sel,
  output logic [1:0] res_sel,
  output logic       out_sel,
  output logic       reconfig_start,
  output logic [1:0] reconfig_res,
  output logic       tg_reset,
  output logic       blank,
  output logic       busy,
  output logic       lock_err
);

  import vmode_pkg::*;

  localparam logic [CNT_W-1:0] BLANK_TERM   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_TERM  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(LOCK_TIMEOUT - 1);

  vmode_state_e     state_q, state_d;
  vmode_sel_t       sel_q, sel_d, tgt_q, tgt_d, req;
  logic             reconfig_start_q, reconfig_start_d;
  logic [1:0]       reconfig_res_q, reconfig_res_d;
  logic             tg_reset_q, tg_reset_d;
  logic             blank_q, blank_d;
  logic             lock_err_q, lock_err_d;
  logic             seen_low_q, seen_low_d;
  logic             lock_prev_q;
  logic             busy_q;
  logic             cnt_clr, cnt_en, cnt_hit;
  logic [CNT_W-1:0] cnt_term;
  logic             lock_rise;

  assign req       = {req_img, req_res, req_out};
  assign lock_rise = clk_locked & ~lock_prev_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_i (cnt_term),
    .hit_o  (cnt_hit)
  );

  // Next-state and next-output decode; soft reset overrides every state
  always_comb begin
    state_d          = state_q;
    sel_d            = sel_q;
    tgt_d            = tgt_q;
    reconfig_start_d = 1'b0;
    reconfig_res_d   = reconfig_res_q;
    tg_reset_d       = tg_reset_q;
    blank_d          = blank_q;
    lock_err_d       = lock_err_q;
    seen_low_d       = seen_low_q;
    cnt_clr          = 1'b0;
    cnt_en           = 1'b0;
    cnt_term         = '0;

    if (req_soft_rst) begin
      state_d    = ST_BOOT;
      sel_d      = '0;
      lock_err_d = 1'b0;
      tg_reset_d = 1'b1;
      blank_d    = 1'b1;
      cnt_clr    = 1'b1;
      // Return the pixel clock to the default resolution if it was moved
      if (sel_q.res != RES_640) begin
        reconfig_start_d = 1'b1;
        reconfig_res_d   = RES_640;
      end
    end else begin
      case (state_q)
        ST_BOOT: begin
          if (clk_locked) begin
            state_d = ST_SETTLE;
            cnt_clr = 1'b1;
          end
        end

        ST_IDLE: begin
          if (req != sel_q) begin
            tgt_d   = req;
            state_d = ST_WAIT_FRAME;
          end
        end

        ST_WAIT_FRAME: begin
          // Target follows the request so the value at frame_end is used
          tgt_d = req;
          if (req == sel_q) begin
            state_d = ST_IDLE;
          end else if (frame_end) begin
            state_d = ST_BLANK;
            blank_d = 1'b1;
            cnt_clr = 1'b1;
          end
        end

        ST_BLANK: begin
          cnt_en   = 1'b1;
          cnt_term = BLANK_TERM;
          if (cnt_hit) begin
            if (tgt_q.res != sel_q.res) begin
              state_d          = ST_RECONFIG;
              tg_reset_d       = 1'b1;
              reconfig_start_d = 1'b1;
              reconfig_res_d   = tgt_q.res;
              seen_low_d       = 1'b0;
              cnt_clr          = 1'b1;
            end else begin
              state_d = ST_APPLY;
            end
          end
        end

        ST_RECONFIG: begin
          cnt_en   = 1'b1;
          cnt_term = TIMEOUT_TERM;
          if (!clk_locked) begin
            seen_low_d = 1'b1;
          end
          // A lock that never dropped is not a fresh lock
          if (seen_low_q && clk_locked) begin
            state_d = ST_APPLY;
          end else if (cnt_hit) begin
            state_d    = ST_ERR;
            lock_err_d = 1'b1;
          end
        end

        ST_APPLY: begin
          sel_d = tgt_q;
          if (tg_reset_q) begin
            state_d = ST_SETTLE;
            cnt_clr = 1'b1;
          end else begin
            state_d = ST_IDLE;
            blank_d = 1'b0;
          end
        end

        ST_SETTLE: begin
          cnt_en   = 1'b1;
          cnt_term = SETTLE_TERM;
          if (cnt_hit) begin
            state_d    = ST_IDLE;
            tg_reset_d = 1'b0;
            blank_d    = 1'b0;
          end
        end

        ST_ERR: begin
          // Late lock completes the failed attempt; a different request
          // retries at once since the timing generator is not producing frames
          if (lock_rise) begin
            state_d = ST_APPLY;
          end else if (req != tgt_q) begin
            tgt_d   = req;
            state_d = ST_BLANK;
            cnt_clr = 1'b1;
          end
        end

        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q          <= ST_BOOT;
      sel_q            <= '0;
      tgt_q            <= '0;
      reconfig_start_q <= 1'b0;
      reconfig_res_q   <= RES_640;
      tg_reset_q       <= 1'b1;
      blank_q          <= 1'b1;
      lock_err_q       <= 1'b0;
      seen_low_q       <= 1'b0;
      lock_prev_q      <= 1'b0;
      busy_q           <= 1'b1;
    end else begin
      state_q          <= state_d;
      sel_q            <= sel_d;
      tgt_q            <= tgt_d;
      reconfig_start_q <= reconfig_start_d;
      reconfig_res_q   <= reconfig_res_d;
      tg_reset_q       <= tg_reset_d;
      blank_q          <= blank_d;
      lock_err_q       <= lock_err_d;
      seen_low_q       <= seen_low_d;
      lock_prev_q      <= clk_locked;
      busy_q           <= (state_d != ST_IDLE);
    end
  end

  assign img_sel        = sel_q.img;
  assign res_sel        = sel_q.res;
  assign out_sel        = sel_q.out;
  assign reconfig_start = reconfig_start_q;
  assign reconfig_res   = reconfig_res_q;
  assign tg_reset       = tg_reset_q;
  assign blank          = blank_q;
  assign busy           = busy_q;
  assign lock_err       = lock_err_q;

endmodule
`default_nettype wire

// File: tb/tb_video_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_mode_sequencer
// Description : Directed and randomized self-checking bench for
//               video_mode_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_video_mode_sequencer;

  localparam int BLANK  = 16;
  localparam int SETTLE = 1024;
  localparam int LOCKTO = 64;
  localparam int CW     = 21;

  localparam int S_TGRST = 0;
  localparam int S_BLANK = 1;
  localparam int S_RCS   = 2;
  localparam int S_LERR  = 3;
  localparam int S_RES   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_img, req_res;
  logic       req_out, req_soft_rst, frame_end, clk_locked;
  logic [1:0] img_sel, res_sel, reconfig_res;
  logic       out_sel, reconfig_start, tg_reset, blank, busy, lock_err;

  int vectors = 0, miscompares = 0;
  int rs_count = 0, blank_cnt = 0, tgr_cnt = 0;

  // Reference model: the selection the specification says is applied
  logic [1:0] m_img, m_res;
  logic       m_out;

  always #5 clk = ~clk;

  video_mode_sequencer #(
    .BLANK_CYCLES  (BLANK),
    .SETTLE_CYCLES (SETTLE),
    .LOCK_TIMEOUT  (LOCKTO),
    .CNT_W         (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .req_img        (req_img),
    .req_res        (req_res),
    .req_out        (req_out),
    .req_soft_rst   (req_soft_rst),
    .frame_end      (frame_end),
    .clk_locked     (clk_locked),
    .img_sel        (img_sel),
    .res_sel        (res_sel),
    .out_sel        (out_sel),
    .reconfig_start (reconfig_start),
    .reconfig_res   (reconfig_res),
    .tg_reset       (tg_reset),
    .blank          (blank),
    .busy           (busy),
    .lock_err       (lock_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
    if (reconfig_start === 1'b1) rs_count++;
    if (blank === 1'b1) blank_cnt++;
    if (tg_reset === 1'b1) tgr_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sample(input int sig);
    logic [1:0] r;
    r = '0;
    case (sig)
      S_TGRST: r = {1'b0, tg_reset};
      S_BLANK: r = {1'b0, blank};
      S_RCS:   r = {1'b0, reconfig_start};
      S_LERR:  r = {1'b0, lock_err};
      S_RES:   r = res_sel;
      default: r = 2'bxx;
    endcase
    return r;
  endfunction

  // Steps until the chosen output equals val; n = steps taken, -1 if never
  task automatic wait_until(input int sig, input logic [1:0] val, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (sample(sig) === val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_frame();
    blank_cnt = 0;
    tgr_cnt   = 0;
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  task automatic check_sel(input string tag);
    check({tag, "_img"}, 32'(img_sel), 32'(m_img));
    check({tag, "_res"}, 32'(res_sel), 32'(m_res));
    check({tag, "_out"}, 32'(out_sel), 32'(m_out));
  endtask

  // One random request taken through a frame boundary
  task automatic rand_txn(input int idx);
    logic [1:0] ni, nr;
    logic       no;
    int         d, lowlen, n, rs0;
    logic       chg, rchg;
    string      t;
    t      = $sformatf("rnd%0d", idx);
    ni     = 2'($urandom_range(0, 3));
    nr     = 2'($urandom_range(0, 3));
    no     = 1'($urandom_range(0, 1));
    d      = int'($urandom_range(1, 20));
    lowlen = int'($urandom_range(5, 40));
    chg    = ({ni, nr, no} != {m_img, m_res, m_out});
    rchg   = (nr != m_res);
    req_img = ni; req_res = nr; req_out = no;
    repeat (d) step();
    check({t, "_busy_pre"}, 32'(busy), 32'(chg));
    check_sel({t, "_held"});
    rs0 = rs_count;
    pulse_frame();
    if (!chg) begin
      repeat (BLANK + 4) step();
      check({t, "_noblank"}, 32'(blank_cnt), 32'd0);
      check({t, "_idle"}, 32'(busy), 32'd0);
    end else if (!rchg) begin
      wait_until(S_BLANK, 2'd0, BLANK + 8, n);
      check({t, "_blank_lat"}, 32'(n), 32'(BLANK + 1));
      check({t, "_blank_len"}, 32'(blank_cnt), 32'(BLANK + 1));
      check({t, "_tgr"}, 32'(tgr_cnt), 32'd0);
    end else begin
      wait_until(S_RCS, 2'd1, BLANK + 8, n);
      check({t, "_rcs_lat"}, 32'(n), 32'(BLANK));
      check({t, "_rcs_res"}, 32'(reconfig_res), 32'(nr));
      clk_locked = 1'b0;
      repeat (lowlen) step();
      check_sel({t, "_inreconf"});
      clk_locked = 1'b1;
      wait_until(S_RES, nr, 8, n);
      check({t, "_apply_lat"}, 32'(n), 32'd2);
      wait_until(S_TGRST, 2'd0, SETTLE + 8, n);
      check({t, "_settle"}, 32'(n), 32'(SETTLE));
    end
    m_img = ni; m_res = nr; m_out = no;
    check_sel({t, "_final"});
    check({t, "_blank_end"}, 32'(blank), 32'd0);
    check({t, "_rcs_cnt"}, 32'(rs_count - rs0), 32'(rchg));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rs0;
    rst = 1'b1;
    req_img = 2'd0; req_res = 2'd0; req_out = 1'b0;
    req_soft_rst = 1'b0; frame_end = 1'b0; clk_locked = 1'b0;
    m_img = 2'd0; m_res = 2'd0; m_out = 1'b0;

    // Reset state
    step();
    check_sel("rst");
    check("rst_rcs", 32'(reconfig_start), 32'd0);
    check("rst_rcr", 32'(reconfig_res), 32'd0);
    check("rst_tgr", 32'(tg_reset), 32'd1);
    check("rst_blank", 32'(blank), 32'd1);
    check("rst_lerr", 32'(lock_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    step();
    rst = 1'b0;

    // Boot waits for lock, then settles
    repeat (4) step();
    check("boot_tgr", 32'(tg_reset), 32'd1);
    check("boot_busy", 32'(busy), 32'd1);
    clk_locked = 1'b1;
    wait_until(S_TGRST, 2'd0, SETTLE + 20, n);
    check("boot_settle", 32'(n), 32'(SETTLE + 1));
    check("boot_blank", 32'(blank), 32'd0);
    check("boot_busy_end", 32'(busy), 32'd0);
    check_sel("boot");

    // Image-only change waits for frame_end, no reconfiguration
    req_img = 2'd1;
    repeat (5) step();
    check("img_wait_sel", 32'(img_sel), 32'd0);
    check("img_wait_busy", 32'(busy), 32'd1);
    check("img_wait_blank", 32'(blank), 32'd0);
    rs0 = rs_count;
    pulse_frame();
    check("img_blank_on", 32'(blank), 32'd1);
    wait_until(S_BLANK, 2'd0, BLANK + 10, n);
    m_img = 2'd1;
    check("img_blank_lat", 32'(n), 32'(BLANK + 1));
    check("img_blank_len", 32'(blank_cnt), 32'(BLANK + 1));
    check_sel("img");
    check("img_tgr", 32'(tgr_cnt), 32'd0);
    check("img_rcs", 32'(rs_count - rs0), 32'd0);

    // Request toggled away and back before frame_end
    req_res = 2'd2;
    repeat (3) step();
    req_res = 2'd0;
    repeat (2) step();
    check("tog_busy", 32'(busy), 32'd0);
    rs0 = rs_count;
    pulse_frame();
    repeat (BLANK + 4) step();
    check("tog_blank", 32'(blank_cnt), 32'd0);
    check("tog_rcs", 32'(rs_count - rs0), 32'd0);
    check_sel("tog");

    // Resolution change 00 -> 11 with a 50-cycle lock drop
    req_res = 2'd3;
    repeat (3) step();
    rs0 = rs_count;
    pulse_frame();
    wait_until(S_RCS, 2'd1, BLANK + 10, n);
    check("res_rcs_lat", 32'(n), 32'(BLANK));
    check("res_rcr", 32'(reconfig_res), 32'd3);
    check("res_tgr_on", 32'(tg_reset), 32'd1);
    step();
    check("res_rcs_pulse", 32'(reconfig_start), 32'd0);
    clk_locked = 1'b0;
    repeat (50) step();
    check_sel("res_hold");
    clk_locked = 1'b1;
    wait_until(S_RES, 2'd3, 8, n);
    m_res = 2'd3;
    check("res_apply_lat", 32'(n), 32'd2);
    check("res_tgr_held", 32'(tg_reset), 32'd1);
    wait_until(S_TGRST, 2'd0, SETTLE + 10, n);
    check("res_settle", 32'(n), 32'(SETTLE));
    check("res_rcs_cnt", 32'(rs_count - rs0), 32'd1);
    check("res_blank_end", 32'(blank), 32'd0);

    // Lock timeout: lock stays low after the reconfig request
    req_res = 2'd2;
    repeat (3) step();
    pulse_frame();
    clk_locked = 1'b0;
    wait_until(S_RCS, 2'd1, BLANK + 10, n);
    check("to_rcs_lat", 32'(n), 32'(BLANK - 1 + 1));
    wait_until(S_LERR, 2'd1, LOCKTO + 10, n);
    check("to_lerr_lat", 32'(n), 32'(LOCKTO));
    check_sel("to_err");
    check("to_busy", 32'(busy), 32'd1);
    check("to_tgr", 32'(tg_reset), 32'd1);
    check("to_blank", 32'(blank), 32'd1);
    repeat (5) step();
    check("to_stay", 32'(res_sel), 32'd3);
    clk_locked = 1'b1;
    wait_until(S_RES, 2'd2, 8, n);
    m_res = 2'd2;
    check("to_apply_lat", 32'(n), 32'd2);
    check("to_lerr_sticky", 32'(lock_err), 32'd1);
    wait_until(S_TGRST, 2'd0, SETTLE + 10, n);
    check("to_settle", 32'(n), 32'(SETTLE));
    check("to_lerr_idle", 32'(lock_err), 32'd1);
    check("to_busy_end", 32'(busy), 32'd0);

    // Soft reset during reconfiguration with res_sel=10
    req_res = 2'd3;
    repeat (3) step();
    pulse_frame();
    wait_until(S_RCS, 2'd1, BLANK + 10, n);
    check("sr_rcs_lat", 32'(n), 32'(BLANK));
    rs0 = rs_count;
    repeat (2) step();
    req_soft_rst = 1'b1;
    step();
    m_img = 2'd0; m_res = 2'd0; m_out = 1'b0;
    check_sel("sr");
    check("sr_lerr", 32'(lock_err), 32'd0);
    check("sr_tgr", 32'(tg_reset), 32'd1);
    check("sr_blank", 32'(blank), 32'd1);
    check("sr_rcs", 32'(reconfig_start), 32'd1);
    check("sr_rcr", 32'(reconfig_res), 32'd0);
    repeat (3) step();
    check("sr_busy", 32'(busy), 32'd1);
    check("sr_rcs_cnt", 32'(rs_count - rs0), 32'd1);
    req_img = 2'd0; req_res = 2'd0; req_out = 1'b0;
    req_soft_rst = 1'b0;
    wait_until(S_TGRST, 2'd0, SETTLE + 20, n);
    check("sr_settle", 32'(n), 32'(SETTLE + 1));
    check("sr_busy_end", 32'(busy), 32'd0);

    // Randomized requests against the model
    for (int i = 0; i < 8; i++) begin
      rand_txn(i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
